// File: rtl/mac_vec_engine_if.sv
// mac_vec_engine_if
//   Stream-side bundle for mac_vec_engine: the two host-to-FPGA operand FIFOs
//   (A, B; standard non-FWFT, data valid the cycle after rden) and the
//   FPGA-to-host result FIFO.
//   master : engine side (drives rden / wren / result word / sat flag)
//   slave  : FIFO side
interface mac_vec_engine_if #(
  parameter int DW = 16,
  parameter int OW = 32
);
  logic          a_empty;
  logic          a_rden;
  logic [DW-1:0] a_dout;
  logic          b_empty;
  logic          b_rden;
  logic [DW-1:0] b_dout;
  logic          res_full;
  logic          res_wren;
  logic [OW-1:0] res_din;
  logic          sat;

  modport master (
    input  a_empty, a_dout, b_empty, b_dout, res_full,
    output a_rden, b_rden, res_wren, res_din, sat
  );

  modport slave (
    output a_empty, a_dout, b_empty, b_dout, res_full,
    input  a_rden, b_rden, res_wren, res_din, sat
  );
endinterface

// File: rtl/mac_vec_engine.sv
// mac_vec_engine
//   Signed dot-product engine: reads VEC_LEN operand pairs from FIFOs A and B,
//   accumulates a*b in an AW-bit accumulator through a 2-stage pipeline and
//   writes the result, saturated to OW bits, to the result FIFO.
//   Optional feature macro MAC_NORM_EN: also accumulates |A|^2 and |B|^2 and
//   writes three words per vector (dot, nA, nB).
// Ports:
//   bus_clk   sole clock
//   rst_n     asynchronous active-low reset
//   clr       synchronous clear, overrides everything
//   bus       mac_vec_engine_if.master (FIFO A/B read side, result write side)
//   busy      high while any pair or result is in flight
//   vec_count completed vectors, wraps modulo 2^CW
module mac_vec_engine #(
  parameter int DW      = 16,
  parameter int OW      = 32,
  parameter int AW      = 48,
  parameter int VEC_LEN = 128,
  parameter int CW      = 16
) (
  input  logic                    bus_clk,
  input  logic                    rst_n,
  input  logic                    clr,
  mac_vec_engine_if.master        bus,
  output logic                    busy,
  output logic [CW-1:0]           vec_count
);

  localparam int IW = $clog2(VEC_LEN + 1);
  localparam logic [IW-1:0] LEN = IW'(VEC_LEN);
`ifdef MAC_NORM_EN
  localparam logic [1:0] LAST_W = 2'd2;
`else
  localparam logic [1:0] LAST_W = 2'd0;
`endif
  // Comparison width wide enough for both the accumulator and the OW limits
  localparam int XW = ((AW > OW) ? AW : OW) + 1;
  localparam logic signed [XW-1:0] SMAX = {{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [XW-1:0] SMIN = {{(XW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  if (VEC_LEN < 1) begin : g_len_chk
    $error("mac_vec_engine: VEC_LEN must be at least 1");
  end
  if (AW < 2*DW + $clog2(VEC_LEN)) begin : g_aw_chk
    $error("mac_vec_engine: AW too narrow for 2*DW + clog2(VEC_LEN)");
  end

  typedef enum logic [1:0] {ACCUM, FLUSH, EMIT} state_t;

  state_t                 state;
  logic                   run_q;
  logic [IW-1:0]          issued;
  logic                   flush_q;
  logic [1:0]             wsel;
  logic                   v0, v1;
  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   acc;
`ifdef MAC_NORM_EN
  logic signed [2*DW-1:0] pa, pb;
  logic signed [AW-1:0]   na, nb;
`endif

  logic                   issue, wr, clip;
  logic signed [2*DW-1:0] ax, bx;
  logic signed [AW-1:0]   word;
  logic [OW-1:0]          wval;

  function automatic logic [OW:0] saturate(input logic signed [AW-1:0] v);
    logic signed [XW-1:0] x;
    x = XW'(v);
    if (x > SMAX)      return {1'b1, SMAX[OW-1:0]};
    else if (x < SMIN) return {1'b1, SMIN[OW-1:0]};
    else               return {1'b0, x[OW-1:0]};
  endfunction

  // Read enables must see the FIFO empty flags of the same cycle (non-FWFT
  // FIFO updates empty right after the read edge), so they are combinational.
  // run_q keeps them low until the first clock edge after reset release.
  assign issue = run_q && !clr && (state == ACCUM) && !bus.a_empty &&
                 !bus.b_empty && (issued < LEN);
  assign bus.a_rden = issue;
  assign bus.b_rden = issue;

  assign wr           = (state == EMIT) && !bus.res_full && !clr;
  assign bus.res_wren = wr;
  assign bus.res_din  = (state == EMIT) ? wval : '0;
  assign bus.sat      = wr & clip;
  assign busy         = (state != ACCUM) || (issued != '0) || v0 || v1;

  assign ax = (2*DW)'($signed(bus.a_dout));
  assign bx = (2*DW)'($signed(bus.b_dout));

  always_comb begin
    word = acc;
`ifdef MAC_NORM_EN
    case (wsel)
      2'd1:    word = na;
      2'd2:    word = nb;
      default: word = acc;
    endcase
`endif
    {clip, wval} = saturate(word);
  end

  always_ff @(posedge bus_clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  always_ff @(posedge bus_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      issued    <= '0;
      flush_q   <= 1'b0;
      wsel      <= '0;
      v0        <= 1'b0;
      v1        <= 1'b0;
      prod      <= '0;
      acc       <= '0;
      vec_count <= '0;
`ifdef MAC_NORM_EN
      pa <= '0;
      pb <= '0;
      na <= '0;
      nb <= '0;
`endif
    end else if (clr) begin
      state     <= ACCUM;
      issued    <= '0;
      flush_q   <= 1'b0;
      wsel      <= '0;
      v0        <= 1'b0;
      v1        <= 1'b0;
      prod      <= '0;
      acc       <= '0;
      vec_count <= '0;
`ifdef MAC_NORM_EN
      pa <= '0;
      pb <= '0;
      na <= '0;
      nb <= '0;
`endif
    end else begin
      // Stage 1: operands arrive the cycle after rden
      v0 <= issue;
      v1 <= v0;
      if (v0) begin
        prod <= ax * bx;
`ifdef MAC_NORM_EN
        pa <= ax * ax;
        pb <= bx * bx;
`endif
      end
      // Stage 2: accumulate (pipeline is empty whenever EMIT clears below)
      if (v1) begin
        acc <= acc + AW'(prod);
`ifdef MAC_NORM_EN
        na <= na + AW'(pa);
        nb <= nb + AW'(pb);
`endif
      end

      case (state)
        ACCUM: begin
          if (issue) begin
            issued <= issued + IW'(1);
            if (issued == LEN - IW'(1)) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (flush_q) begin
            flush_q <= 1'b0;
            state   <= EMIT;
          end else begin
            flush_q <= 1'b1;
          end
        end
        EMIT: begin
          if (wr) begin
            if (wsel == LAST_W) begin
              wsel      <= '0;
              issued    <= '0;
              acc       <= '0;
              vec_count <= vec_count + CW'(1);
              state     <= ACCUM;
`ifdef MAC_NORM_EN
              na <= '0;
              nb <= '0;
`endif
            end else begin
              wsel <= wsel + 2'd1;
            end
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_vec_engine.sv
// tb_mac_vec_engine
//   Scoreboard bench for mac_vec_engine (VEC_LEN=4, DW=16, OW=32, AW=48).
//   Stimulus pushes hand-computed expected words into exp_q; a monitor pops
//   and compares on every result write. FIFO A/B are modelled as non-FWFT
//   FIFOs backed by queues.
module tb_mac_vec_engine;
  localparam int DW = 16;
  localparam int OW = 32;
  localparam int AW = 48;
  localparam int VL = 4;
  localparam int CW = 16;
`ifdef MAC_NORM_EN
  localparam int NW = 3;
`else
  localparam int NW = 1;
`endif

  typedef struct {
    logic [OW-1:0] din;
    logic          sat;
  } exp_t;

  logic          bus_clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic          busy;
  logic [CW-1:0] vec_count;

  mac_vec_engine_if #(.DW(DW), .OW(OW)) bus ();

  mac_vec_engine #(.DW(DW), .OW(OW), .AW(AW), .VEC_LEN(VL), .CW(CW)) dut (
    .bus_clk   (bus_clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .bus       (bus),
    .busy      (busy),
    .vec_count (vec_count)
  );

  exp_t exp_q[$];
  int   qa[$];
  int   qb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   rd_total = 0;
  int   last_rd  = 0;
  bit   lat_chk  = 1'b0;

  initial forever #5 bus_clk = ~bus_clk;
  initial forever begin
    @(posedge bus_clk);
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge bus_clk);
    #2;
  endtask

  task automatic upd_empty();
    bus.a_empty = (qa.size() == 0);
    bus.b_empty = (qb.size() == 0);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push_vec(input int a[VL], input int b[VL]);
    foreach (a[i]) qa.push_back(a[i]);
    foreach (b[i]) qb.push_back(b[i]);
    upd_empty();
  endtask

  task automatic expect_vec(input logic [31:0] d0, input bit s0,
                            input logic [31:0] d1, input bit s1,
                            input logic [31:0] d2, input bit s2);
    exp_q.push_back('{din: d0, sat: s0});
`ifdef MAC_NORM_EN
    exp_q.push_back('{din: d1, sat: s1});
    exp_q.push_back('{din: d2, sat: s2});
`endif
  endtask

  task automatic wait_reads(input int n, input string name);
    for (int i = 0; i < 100 && rd_total < n; i++) step();
    if (rd_total < n) begin
      checks++;
      errors++;
      $display("FAIL %s_reads: got %0d pair reads, expected %0d", name, rd_total, n);
    end
  endtask

  task automatic wait_drain(input int vc, input string name);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) step();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: got %0d results pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    step();
    step();
    @(negedge bus_clk);
    check({name, "_vec_count"}, 64'(vec_count), 64'(vc));
    check({name, "_busy"}, 64'(busy), 64'd0);
  endtask

  // FIFO A/B model: data appears the cycle after rden
  initial begin
    bit ra, rb;
    bus.a_dout  = '0;
    bus.b_dout  = '0;
    bus.a_empty = 1'b1;
    bus.b_empty = 1'b1;
    forever begin
      @(posedge bus_clk);
      ra = bus.a_rden;
      rb = bus.b_rden;
      #1;
      if (ra) begin
        rd_total++;
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL fifo_a_underflow: got read of empty FIFO A, expected none");
        end else bus.a_dout = DW'(qa.pop_front());
      end
      if (rb) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL fifo_b_underflow: got read of empty FIFO B, expected none");
        end else bus.b_dout = DW'(qb.pop_front());
      end
      upd_empty();
    end
  end

  // Monitor: pairing of read enables, result scoreboard, latency
  initial begin
    int   widx;
    exp_t e;
    widx = 0;
    forever begin
      @(negedge bus_clk);
      checks++;
      if (bus.a_rden !== bus.b_rden || (bus.a_rden && (bus.a_empty || bus.b_empty))) begin
        errors++;
        $display("FAIL rden_pair: got a_rden=%b b_rden=%b a_empty=%b b_empty=%b, expected equal enables only when both non-empty",
                 bus.a_rden, bus.b_rden, bus.a_empty, bus.b_empty);
      end
      if (bus.a_rden) last_rd = cyc;
      if (bus.res_wren && !bus.res_full) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got res_din=0x%0h, expected no write", bus.res_din);
        end else begin
          e = exp_q.pop_front();
          check("res_din", 64'(bus.res_din), 64'(e.din));
          check("sat", 64'(bus.sat), 64'(e.sat));
        end
        if (widx == 0 && lat_chk) check("latency", 64'(cyc - last_rd), 64'd3);
        widx = (widx + 1) % NW;
      end
    end
  end

  initial begin
    int          base, gap_rd, hold_bad;
    logic [31:0] held;
    rst_n = 1'b0;
    clr = 1'b0;
    bus.res_full = 1'b0;
    repeat (2) step();

    // T1 preloaded during reset: no reads until after release
    push_vec('{1, 2, 3, 4}, '{5, 6, 7, 8});
    expect_vec(32'd70, 0, 32'd30, 0, 32'd174, 0);
    @(negedge bus_clk);
    check("reset_outputs", {bus.a_rden, bus.b_rden, bus.res_wren, bus.sat, busy, bus.res_din, vec_count}, 64'd0);
    step();
    rst_n = 1'b1;
    @(negedge bus_clk);
    check("rden_after_release", {bus.a_rden, bus.b_rden}, 64'd0);
    lat_chk = 1'b1;
    wait_drain(1, "t1");

    // T2/T3 saturation
    push_vec('{-32768, -32768, -32768, -32768}, '{-32768, -32768, -32768, -32768});
    expect_vec(32'h7FFF_FFFF, 1, 32'h7FFF_FFFF, 1, 32'h7FFF_FFFF, 1);
    wait_drain(2, "t2");
    push_vec('{-32768, -32768, -32768, -32768}, '{32767, 32767, 32767, 32767});
    expect_vec(32'h8000_0000, 1, 32'h7FFF_FFFF, 1, 32'h7FFF_FFFF, 1);
    wait_drain(3, "t3");

    // T4 FIFO B runs empty after 3 pairs for 10 cycles
    base = rd_total;
    qa.push_back(10); qa.push_back(-20); qa.push_back(30); qa.push_back(-40);
    qb.push_back(1);  qb.push_back(2);   qb.push_back(3);
    upd_empty();
    expect_vec(32'hFFFF_FF9C, 0, 32'd3000, 0, 32'd30, 0);
    wait_reads(base + 3, "t4");
    gap_rd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge bus_clk);
      if (bus.a_rden || bus.b_rden) gap_rd++;
      step();
    end
    check("gap_no_rden", 64'(gap_rd), 64'd0);
    qb.push_back(4);
    upd_empty();
    wait_drain(4, "t4");

    // T5 backpressure at EMIT for 20 cycles
    bus.res_full = 1'b1;
    lat_chk = 1'b0;
    base = rd_total;
    push_vec('{1, 1, 1, 1}, '{-3, 4, -5, 6});
    expect_vec(32'd2, 0, 32'd4, 0, 32'd86, 0);
    wait_reads(base + 4, "t5");
    step();
    step();
    hold_bad = 0;
    held = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge bus_clk);
      if (i == 0) held = bus.res_din;
      if (bus.res_wren || bus.a_rden || bus.b_rden || bus.res_din !== held) hold_bad++;
      step();
    end
    check("bp_held_din", 64'(held), 64'd2);
    check("bp_hold_quiet", 64'(hold_bad), 64'd0);
    bus.res_full = 1'b0;
    @(negedge bus_clk);
    check("bp_release_wren", 64'(bus.res_wren), 64'd1);
    wait_drain(5, "t5");
    lat_chk = 1'b1;

    // T6a clr mid-vector: 2 of 4 pairs consumed, nothing written
    base = rd_total;
    push_vec('{9, 9, 0, 0}, '{9, 9, 0, 0});
    void'(qa.pop_back()); void'(qa.pop_back());
    void'(qb.pop_back()); void'(qb.pop_back());
    upd_empty();
    wait_reads(base + 2, "t6a");
    clr = 1'b1;
    step();
    clr = 1'b0;
    @(negedge bus_clk);
    check("clr_vec_count", 64'(vec_count), 64'd0);
    check("clr_busy", 64'(busy), 64'd0);

    // T6b clr coinciding with a would-be write
    step();
    bus.res_full = 1'b1;
    base = rd_total;
    push_vec('{2, 2, 2, 2}, '{2, 2, 2, 2});
    wait_reads(base + 4, "t6b");
    step();
    step();
    clr = 1'b1;
    bus.res_full = 1'b0;
    @(negedge bus_clk);
    check("clr_blocks_wren", 64'(bus.res_wren), 64'd0);
    step();
    clr = 1'b0;
    push_vec('{1, 1, 1, 1}, '{2, 2, 2, 2});
    expect_vec(32'd8, 0, 32'd4, 0, 32'd16, 0);
    wait_drain(1, "t6");

    // T7 asynchronous reset while holding in EMIT
    bus.res_full = 1'b1;
    base = rd_total;
    push_vec('{5, 5, 5, 5}, '{5, 5, 5, 5});
    wait_reads(base + 4, "t7");
    step();
    step();
    @(negedge bus_clk);
    check("pre_rst_din", 64'(bus.res_din), 64'd100);
    step();
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {bus.a_rden, bus.b_rden, bus.res_wren, bus.sat, busy, bus.res_din, vec_count}, 64'd0);
    step();
    step();
    rst_n = 1'b1;
    bus.res_full = 1'b0;
    @(negedge bus_clk);
    check("post_rst_state", {vec_count, bus.a_rden, bus.b_rden}, 64'd0);
    step();
    push_vec('{1, 2, 3, 4}, '{1, 1, 1, 1});
    expect_vec(32'd10, 0, 32'd30, 0, 32'd4, 0);
    wait_drain(1, "t7");

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_vec_engine.md
# mac_vec_engine

Parametrised signed dot-product engine between the two host-to-FPGA 32-bit FIFOs (vector A, vector B) and the FPGA-to-host result FIFO on the Xillybus stream path. It is the successor to the fixed single-result MAC used for face-search cosine scoring. Each vector length, operand width and accumulator width is set by parameter, and results are saturated to the output width. It optionally also emits the squared norms |A|² and |B|², so that host-side cosine similarity needs no second pass.

## Interface
- DW, 16: operand width; signed two's complement.
- OW, 32: result word width.
- AW, 48: accumulator width. Elaboration error if AW < 2*DW + clog2(VEC_LEN).
- VEC_LEN, 128: element pairs per vector; must be ≥1 (elaboration error otherwise).
- CW, 16: width of vec_count.

Ports:
- bus_clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear, driven from the stream open/close logic.
- a_empty  in  1  FIFO A empty.
- a_rden  out  1  FIFO A read enable.
- a_dout  in  DW  FIFO A data, valid the cycle after a_rden (standard, non-FWFT FIFO).
- b_empty  in  1  FIFO B empty.
- b_rden  out  1  FIFO B read enable.
- b_dout  in  DW  FIFO B data, same timing as a_dout.
- res_full  in  1  result FIFO full.
- res_wren  out  1  result FIFO write enable.
- res_din  out  OW  result word.
- sat  out  1  high together with res_wren when the word being written was clipped.
- busy  out  1  high while any pair or result is in flight.
- vec_count  out  CW  count of completed vectors; wraps modulo 2^CW.

## Operation
- States: ACCUM, FLUSH, EMIT. Reset and clr both enter ACCUM with all counters and accumulators at 0.
- ACCUM, issue: a_rden and b_rden are always asserted together. They assert only when a_empty=0, b_empty=0 and issued<VEC_LEN. One FIFO is never read alone.
- ACCUM, count: each issue increments issued. When issued reaches VEC_LEN, the state moves to FLUSH.
- FIFO goes empty mid-vector: issue stalls. Pairs already in the pipeline still complete. Partial sums are held.
- Pipeline stage 1 (cycle after issue): the operands are captured and prod = a*b (2*DW bits, signed) is registered.
- Pipeline stage 2: acc += sign-extended prod.
- FLUSH: lasts 2 cycles so the pipeline drains. Then EMIT.
- EMIT, writing: res_wren=1 in every cycle that res_full=0. No FIFO reads occur in EMIT.
- EMIT, one word per vector (default): the word is sat(acc).
- Saturation: a value above 2^(OW-1)-1 is written as 0x7FFFFFFF (for OW=32). A value below -2^(OW-1) is written as 0x80000000. sat=1 on that write.
- After the last word is written:
  - vec_count increments;
  - acc is zeroed (and the norm accumulators, when present);
  - issued resets to 0;
  - the state returns to ACCUM.
- clr: highest priority over every other event. It discards in-flight pairs and any unwritten result, and zeros vec_count.
- busy: 0 only in ACCUM with issued=0 and both pipeline stages empty.

## Timing
- Reset values: a_rden=0, b_rden=0, res_wren=0, res_din=0, sat=0, busy=0, vec_count=0.
- Latency: with res_full=0, res_wren is first asserted 3 cycles after the cycle of the last rden.
- Throughput: one pair per cycle during ACCUM. Per-vector overhead is 2 + W cycles, where W is the number of result words.
- Backpressure: res_full=1 holds EMIT with res_din stable. A write happens only in a cycle where res_full=0 and res_wren=1.
- Simultaneous clr and res_wren: the write is suppressed (res_wren=0 in that cycle).
- rst_n deassertion: outputs leave their reset values no earlier than the first bus_clk edge after release.

## Configuration
- MAC_NORM_EN defined:
  - two further AW-bit accumulators, nA += a*a and nB += b*b, run in stage 2;
  - EMIT writes three words in order: sat(acc), sat(nA), sat(nB);
  - each word waits on res_full independently, and sat applies per word;
  - vec_count increments after the third word.
- MAC_NORM_EN undefined: the norm accumulators are absent and EMIT writes one word per vector.

## Test plan
- VEC_LEN=4, A={1,2,3,4}, B={5,6,7,8}, both FIFOs preloaded → res_din=70 and sat=0, res_wren 3 cycles after the 4th rden, vec_count=1. With MAC_NORM_EN the words are 70, 30, 174.
- DW=16, VEC_LEN=4, A=B={-32768 ×4} → true sum 2^32 > 0x7FFFFFFF, so res_din=0x7FFFFFFF and sat=1. With A={-32768 ×4}, B={32767 ×4} the sum is -4294836224 < -2^31, so res_din=0x80000000 and sat=1.
- VEC_LEN=8: FIFO B runs empty after 3 pairs for 10 cycles → no rden during the gap, a_rden always equals b_rden, final sum still correct.
- res_full held high for 20 cycles at EMIT → res_din stable, res_wren=0, no FIFO reads. The write occurs in the first cycle res_full=0.
- clr pulsed after 5 of 8 pairs → no result written. A following full vector A={1×8}, B={2×8} gives res_din=16.
- rst_n asserted asynchronously mid-EMIT → all outputs return to 0 without waiting for a clock edge, then the engine restarts cleanly at vec_count=0.
